// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo -- writeback trace capture buffer.
//
// Sits behind the core's debug writeback port. Every register-file write the
// core reports is stamped with a sequence number and pushed into a FIFO. A
// consumer drains the FIFO through a valid/ready handshake. The core cannot
// stall, so a write that arrives while the FIFO is full is dropped. A drop
// sets a sticky flag, bumps a saturating counter, and still uses up a
// sequence number. Gaps in tr_seq therefore show the consumer where events
// were lost.
//
// Optional feature (compile-time macro):
//   WB_TRACE_SKIP_R0_EN -- writes to r0 are not qualifying events. They are
//                          not stored, not counted, and use no sequence number.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, >= 2)
//   SEQ_W  sequence-number and drop-counter width
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   trace_en            capture enable
//   debug_wb_pc/rf_wen/rf_wnum/rf_wdata   writeback event from the core
//   tr_ready            consumer accepts the head entry
//   clr                 clears overflow and drop_cnt
//   tr_valid            FIFO non-empty
//   tr_pc/wen/wnum/wdata/seq              head entry fields
//   tr_level            number of entries held
//   overflow            sticky: at least one event dropped
//   drop_cnt            saturating count of dropped events
module wb_trace_fifo #(
  parameter int DEPTH = 16,
  parameter int SEQ_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       trace_en,
  input  logic [31:0]                debug_wb_pc,
  input  logic [3:0]                 debug_wb_rf_wen,
  input  logic [4:0]                 debug_wb_rf_wnum,
  input  logic [31:0]                debug_wb_rf_wdata,
  input  logic                       tr_ready,
  input  logic                       clr,
  output logic                       tr_valid,
  output logic [31:0]                tr_pc,
  output logic [3:0]                 tr_wen,
  output logic [4:0]                 tr_wnum,
  output logic [31:0]                tr_wdata,
  output logic [SEQ_W-1:0]           tr_seq,
  output logic [$clog2(DEPTH):0]     tr_level,
  output logic                       overflow,
  output logic [SEQ_W-1:0]           drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0]      pc;
    logic [3:0]       wen;
    logic [4:0]       wnum;
    logic [31:0]      wdata;
    logic [SEQ_W-1:0] seq;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [LVL_W-1:0] level;
  logic [SEQ_W-1:0] seq_cnt;

  logic   qual, full, empty, pop, push, drop;
  entry_t wr_ent, head;

  // ---------------------------------------------------------------------------
  // Event qualification
  // ---------------------------------------------------------------------------
`ifdef WB_TRACE_SKIP_R0_EN
  assign qual = trace_en && (debug_wb_rf_wen != 4'h0) && (debug_wb_rf_wnum != 5'd0);
`else
  assign qual = trace_en && (debug_wb_rf_wen != 4'h0);
`endif

  assign full  = (level == LVL_W'(DEPTH));
  assign empty = (level == '0);
  assign pop   = !empty && tr_ready;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the push.
  assign push  = qual && (!full || pop);
  assign drop  = qual && full && !pop;

  always_comb begin
    wr_ent       = '0;
    wr_ent.pc    = debug_wb_pc;
    wr_ent.wen   = debug_wb_rf_wen;
    wr_ent.wnum  = debug_wb_rf_wnum;
    wr_ent.wdata = debug_wb_rf_wdata;
    wr_ent.seq   = seq_cnt;
  end

  // ---------------------------------------------------------------------------
  // Storage. It is zeroed at reset so that the head outputs read 0 (not X)
  // while the FIFO is empty.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= wr_ent;
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, level, sequence counter. The pointers are PTR_W bits wide and
  // wrap naturally because DEPTH is a power of two.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      seq_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      // Stored and dropped events alike use up a sequence number.
      if (qual) seq_cnt <= seq_cnt + SEQ_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Overflow tracking. When a drop and clr land in the same cycle, the drop
  // wins: the counter restarts at 1 instead of 0.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr)
        drop_cnt <= SEQ_W'(1);
      else if (drop_cnt != '1)
        drop_cnt <= drop_cnt + SEQ_W'(1);
    end else if (clr) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Head outputs, read straight from storage. There is no bypass path from
  // debug_wb_* to tr_*.
  // ---------------------------------------------------------------------------
  assign head     = mem[rd_ptr];
  assign tr_valid = !empty;
  assign tr_pc    = head.pc;
  assign tr_wen   = head.wen;
  assign tr_wnum  = head.wnum;
  assign tr_wdata = head.wdata;
  assign tr_seq   = head.seq;
  assign tr_level = level;

endmodule

// File: tb/tb_wb_trace_fifo.sv
module tb_wb_trace_fifo;

  localparam int DEPTH = 16;
  localparam int SEQ_W = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              trace_en;
  logic [31:0]       debug_wb_pc;
  logic [3:0]        debug_wb_rf_wen;
  logic [4:0]        debug_wb_rf_wnum;
  logic [31:0]       debug_wb_rf_wdata;
  logic              tr_ready;
  logic              clr;
  logic              tr_valid;
  logic [31:0]       tr_pc;
  logic [3:0]        tr_wen;
  logic [4:0]        tr_wnum;
  logic [31:0]       tr_wdata;
  logic [SEQ_W-1:0]  tr_seq;
  logic [4:0]        tr_level;
  logic              overflow;
  logic [SEQ_W-1:0]  drop_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  wb_trace_fifo #(.DEPTH(DEPTH), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .reset(reset), .trace_en(trace_en),
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .tr_ready(tr_ready), .clr(clr), .tr_valid(tr_valid), .tr_pc(tr_pc),
    .tr_wen(tr_wen), .tr_wnum(tr_wnum), .tr_wdata(tr_wdata), .tr_seq(tr_seq),
    .tr_level(tr_level), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    debug_wb_rf_wen = 4'h0;
    tr_ready = 1'b0;
    clr = 1'b0;
  endtask

  task automatic ev(input logic [31:0] pc, input logic [3:0] wen,
                    input logic [4:0] wnum, input logic [31:0] wd);
    debug_wb_pc = pc; debug_wb_rf_wen = wen;
    debug_wb_rf_wnum = wnum; debug_wb_rf_wdata = wd;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; trace_en = 1'b1; clr = 1'b0; tr_ready = 1'b0;
    ev(32'h0, 4'h0, 5'd0, 32'h0);
    do_reset();
    tick();
    chk("rst_valid", tr_valid, 0);
    chk("rst_level", tr_level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_pc", tr_pc, 0);
    chk("rst_seq", tr_seq, 0);

    // Basic capture
    ev(32'hBFC00000, 4'hF, 5'd3, 32'h12345678);
    tick(); idle();
    chk("cap_valid", tr_valid, 1);
    chk("cap_pc", tr_pc, 64'hBFC00000);
    chk("cap_wen", tr_wen, 4'hF);
    chk("cap_wnum", tr_wnum, 3);
    chk("cap_wdata", tr_wdata, 64'h12345678);
    chk("cap_seq", tr_seq, 0);
    chk("cap_level", tr_level, 1);
    tr_ready = 1'b1;
    tick(); idle();
    chk("pop_valid", tr_valid, 0);
    chk("pop_level", tr_level, 0);
    // Ready asserted while empty has no effect.
    tr_ready = 1'b1;
    tick(); idle();
    chk("empty_rdy_level", tr_level, 0);

    // Non-events do not consume sequence numbers.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      ev(32'h100 + i, 4'h0, 5'd5, i);
      tick();
    end
    chk("nonev_level", tr_level, 0);
    ev(32'h200, 4'h3, 5'd6, 32'hAA);
    tick(); idle();
    chk("nonev_seq", tr_seq, 0);
    chk("nonev_wen", tr_wen, 4'h3);

    // Overflow: 20 events with ready low (seq 0..19; 16 stored, 4 dropped).
    do_reset();
    for (int i = 0; i < 20; i++) begin
      ev(32'h1000 + 4 * i, 4'hF, 5'd4, 32'hD000 + i);
      tick();
    end
    idle();
    chk("ovf_level", tr_level, 16);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop", drop_cnt, 4);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain_seq%0d", i), tr_seq, i);
      tr_ready = 1'b1;
      tick();
    end
    idle();
    chk("drain_valid", tr_valid, 0);
    ev(32'h2000, 4'hF, 5'd4, 32'h55);
    tick(); idle();
    chk("next_seq", tr_seq, 20);
    tr_ready = 1'b1;
    tick(); idle();

    // Fill to full (seq 21..36), then push and pop in the same cycle.
    for (int i = 0; i < 16; i++) begin
      ev(32'h3000 + i, 4'h1, 5'd7, i);
      tick();
    end
    idle();
    chk("full_level", tr_level, 16);
    chk("full_head_seq", tr_seq, 21);
    ev(32'h4000, 4'h1, 5'd8, 32'h77);
    tr_ready = 1'b1;
    tick(); idle();
    chk("pp_level", tr_level, 16);
    chk("pp_drop", drop_cnt, 4);
    chk("pp_head_seq", tr_seq, 22);

    // Clear collision: drop and clr together, then clr alone.
    ev(32'h5000, 4'h1, 5'd9, 32'h1);
    clr = 1'b1;
    tick(); idle();
    chk("clrcol_ovf", overflow, 1);
    chk("clrcol_drop", drop_cnt, 1);
    chk("clrcol_level", tr_level, 16);
    clr = 1'b1;
    tick(); idle();
    chk("clr_ovf", overflow, 0);
    chk("clr_drop", drop_cnt, 0);
    chk("clr_level", tr_level, 16);

    // Reset mid-stream with 5 entries held; events offered during reset are ignored.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ev(32'h6000 + i, 4'hF, 5'd10, i);
      tick();
    end
    idle();
    chk("mid_level5", tr_level, 5);
    ev(32'h6100, 4'hF, 5'd11, 32'h9);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0; idle();
    chk("mid_rst_valid", tr_valid, 0);
    chk("mid_rst_level", tr_level, 0);
    tick();
    chk("mid_hold_level", tr_level, 0);
    ev(32'h7000, 4'hF, 5'd0, 32'hE0);
    tick();
    ev(32'h7004, 4'hF, 5'd4, 32'hE4);
    tick(); idle();
    chk("r0_head_seq", tr_seq, 0);
`ifdef WB_TRACE_SKIP_R0_EN
    chk("r0_level", tr_level, 1);
    chk("r0_head_wnum", tr_wnum, 4);
`else
    chk("r0_level", tr_level, 2);
    chk("r0_head_wnum", tr_wnum, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
